// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy group: direction codes, sprite
// facing offsets, screen bounds and the movement helper functions.
package enemy_pkg;

  typedef enum logic [2:0] {
    NO_ACTION = 3'b000,
    UP        = 3'b010,
    DOWN      = 3'b011,
    LEFT      = 3'b100,
    RIGHT     = 3'b101
  } dir_e;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } pos_t;

  localparam logic [5:0] BASE_DOWN  = 6'd0;
  localparam logic [5:0] BASE_LEFT  = 6'd16;
  localparam logic [5:0] BASE_UP    = 6'd32;
  localparam logic [5:0] BASE_RIGHT = 6'd48;

  localparam logic [5:0] TRANSPARENT = 6'h3F;

  localparam logic [8:0] X_MIN = 9'd0;
  localparam logic [8:0] X_MAX = 9'd304;
  localparam logic [7:0] Y_MIN = 8'd0;
  localparam logic [7:0] Y_MAX = 8'd224;

  localparam int         START_X    = 32;
  localparam int         START_STEP = 48;
  localparam logic [7:0] START_Y    = 8'd96;

  function automatic logic [5:0] facing_base(input dir_e d);
    case (d)
      LEFT:    return BASE_LEFT;
      UP:      return BASE_UP;
      RIGHT:   return BASE_RIGHT;
      default: return BASE_DOWN;
    endcase
  endfunction

  // Random override only fires on r[1:0]==11, so chase still dominates.
  function automatic dir_e next_dir(input logic rand_en, input logic [3:0] r,
                                    input logic [8:0] lx, input logic [7:0] ly,
                                    input pos_t p);
    if (rand_en && r[1:0] == 2'b11) begin
      case (r[3:2])
        2'd0:    return UP;
        2'd1:    return DOWN;
        2'd2:    return LEFT;
        default: return RIGHT;
      endcase
    end
    if (ly < p.y) return UP;
    if (ly > p.y) return DOWN;
    if (lx < p.x) return LEFT;
    if (lx > p.x) return RIGHT;
    return NO_ACTION;
  endfunction

  function automatic pos_t step_pos(input pos_t p, input dir_e d);
    pos_t n;
    n = p;
    case (d)
      UP:      if (p.y > Y_MIN) n.y = p.y - 8'd1;
      DOWN:    if (p.y < Y_MAX) n.y = p.y + 8'd1;
      LEFT:    if (p.x > X_MIN) n.x = p.x - 9'd1;
      RIGHT:   if (p.x < X_MAX) n.x = p.x + 9'd1;
      default: n = p;
    endcase
    return n;
  endfunction

  // Maximal-length Galois masks; the MSB is always set so a nonzero state stays nonzero.
  function automatic logic [23:0] lfsr_taps(input int width);
    case (width)
      4:       return 24'h00000C;
      8:       return 24'h0000B8;
      12:      return 24'h000E08;
      16:      return 24'h00B400;
      20:      return 24'h090000;
      24:      return 24'hE10000;
      default: return 24'h000001 << (width - 1);
    endcase
  endfunction

endpackage

// File: rtl/enemy_group_if.sv
// Control/data bundle between the game controller and the enemy group.
interface enemy_group_if #(parameter int NUM_ENEMIES = 4);

  logic                       init;
  logic                       gen_move;
  logic                       move_enemies;
  logic                       draw_enemies;
  logic [8:0]                 link_x_pos;
  logic [7:0]                 link_y_pos;
  logic [NUM_ENEMIES-1:0]     collision;
  logic [NUM_ENEMIES-1:0]     hit;
  logic [5:0]                 colour;

  logic [9*NUM_ENEMIES-1:0]   enemy_x_pos;
  logic [8*NUM_ENEMIES-1:0]   enemy_y_pos;
  logic [3*NUM_ENEMIES-1:0]   enemy_direction;
  logic [NUM_ENEMIES-1:0]     enemy_alive;
  logic [9:0]                 sprite_addr;
  logic [8:0]                 enemy_x_draw;
  logic [7:0]                 enemy_y_draw;
  logic                       VGA_write;
  logic                       draw_done;
  logic                       all_dead;

  modport master (
    output init, gen_move, move_enemies, draw_enemies, link_x_pos, link_y_pos,
           collision, hit, colour,
    input  enemy_x_pos, enemy_y_pos, enemy_direction, enemy_alive, sprite_addr,
           enemy_x_draw, enemy_y_draw, VGA_write, draw_done, all_dead
  );

  modport slave (
    input  init, gen_move, move_enemies, draw_enemies, link_x_pos, link_y_pos,
           collision, hit, colour,
    output enemy_x_pos, enemy_y_pos, enemy_direction, enemy_alive, sprite_addr,
           enemy_x_draw, enemy_y_draw, VGA_write, draw_done, all_dead
  );

endinterface

// File: rtl/enemy_lfsr.sv
// Free-running Galois LFSR; each enemy takes its own 4-bit slice as a random source.
module enemy_lfsr
  import enemy_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reseed_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED = WIDTH'(24'h5A3C91);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clock) begin
    if (reseed_i) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/enemy_group.sv
// Enemy group: per-enemy chase/random movement with health, plus a draw
// sequencer that streams a 16x16 sprite for every live enemy.
module enemy_group
  import enemy_pkg::*;
#(
  parameter int NUM_ENEMIES = 4,
  parameter int MAX_HEALTH  = 3,
  parameter int RAND_MOVE   = 1
) (
  input logic          clock,
  input logic          reset,
  enemy_group_if.slave bus
);

  localparam int LW = 4 * NUM_ENEMIES;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_SEL  = 2'd1;
  localparam logic [1:0] D_PIX  = 2'd2;
  localparam logic [1:0] D_DONE = 2'd3;

  pos_t                   pos_q    [NUM_ENEMIES];
  pos_t                   pos_d    [NUM_ENEMIES];
  dir_e                   dir_q    [NUM_ENEMIES];
  dir_e                   dir_d    [NUM_ENEMIES];
  logic [2:0]             health_q [NUM_ENEMIES];
  logic [2:0]             health_d [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0] alive_q, alive_d;

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] count_q, count_d;
  logic [8:0] x_draw_q;
  logic [7:0] y_draw_q;
  logic       pix_q;
  logic       done_q;

  logic [LW-1:0] lfsr;
  logic          restart;
  logic          found;
  logic [2:0]    found_idx;
  pos_t          sel_pos;
  dir_e          sel_dir;

  assign restart = reset | bus.init;

  enemy_lfsr #(.WIDTH(LW)) u_lfsr (
    .clock    (clock),
    .reseed_i (restart),
    .state_o  (lfsr)
  );

  // A hit on the last health point kills the enemy in the same cycle; dead enemies freeze.
  always_comb begin
    alive_d = alive_q;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      pos_d[i]    = pos_q[i];
      dir_d[i]    = dir_q[i];
      health_d[i] = health_q[i];
      if (alive_q[i]) begin
        if (bus.gen_move)
          dir_d[i] = next_dir(RAND_MOVE != 0, lfsr[4*i +: 4], bus.link_x_pos,
                              bus.link_y_pos, pos_q[i]);
        if (bus.move_enemies) begin
          if (!bus.collision[i]) pos_d[i] = step_pos(pos_q[i], dir_q[i]);
          if (bus.hit[i]) begin
            health_d[i] = health_q[i] - 3'd1;
            if (health_q[i] == 3'd1) alive_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (restart) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        pos_q[i].x  <= 9'(START_X + START_STEP * i);
        pos_q[i].y  <= START_Y;
        dir_q[i]    <= DOWN;
        health_q[i] <= 3'(MAX_HEALTH);
      end
      alive_q <= '1;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      health_q <= health_d;
      alive_q  <= alive_d;
    end
  end

  always_comb begin
    found     = 1'b0;
    found_idx = idx_q;
    sel_pos   = '0;
    sel_dir   = DOWN;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (alive_q[i] && 3'(i) >= idx_q) begin
        found     = 1'b1;
        found_idx = 3'(i);
      end
      if (3'(i) == idx_q) begin
        sel_pos = pos_q[i];
        sel_dir = dir_q[i];
      end
    end
  end

  // Everything except D_DONE holds while draw_enemies is low.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    case (state_q)
      D_IDLE: if (bus.draw_enemies) begin
        state_d = D_SEL;
        idx_d   = 3'd0;
      end
      D_SEL: if (bus.draw_enemies) begin
        if (found) begin
          state_d = D_PIX;
          idx_d   = found_idx;
          count_d = 8'd0;
        end else begin
          state_d = D_DONE;
        end
      end
      D_PIX: if (bus.draw_enemies) begin
        count_d = count_q + 8'd1;
        if (count_q == 8'hFF) begin
          state_d = D_SEL;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (restart) begin
      state_q  <= D_IDLE;
      idx_q    <= 3'd0;
      count_q  <= 8'd0;
      x_draw_q <= 9'd0;
      y_draw_q <= 8'd0;
      pix_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      pix_q   <= (state_q == D_PIX) && bus.draw_enemies;
      done_q  <= (state_d == D_DONE) && (state_q != D_DONE);
      if ((state_q == D_PIX) && bus.draw_enemies) begin
        x_draw_q <= sel_pos.x + {5'd0, count_q[3:0]};
        y_draw_q <= sel_pos.y + {4'd0, count_q[7:4]};
      end
    end
  end

  always_comb begin
    bus.enemy_x_pos     = '0;
    bus.enemy_y_pos     = '0;
    bus.enemy_direction = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      bus.enemy_x_pos[9*i +: 9]     = pos_q[i].x;
      bus.enemy_y_pos[8*i +: 8]     = pos_q[i].y;
      bus.enemy_direction[3*i +: 3] = dir_q[i];
    end
  end

  assign bus.enemy_alive  = alive_q;
  assign bus.all_dead     = ~|alive_q;
  assign bus.sprite_addr  = (state_q == D_PIX)
                            ? {count_q[7:4], facing_base(sel_dir) + {2'b00, count_q[3:0]}}
                            : 10'd0;
  assign bus.enemy_x_draw = x_draw_q;
  assign bus.enemy_y_draw = y_draw_q;
  assign bus.VGA_write    = pix_q && (bus.colour != TRANSPARENT);
  assign bus.draw_done    = done_q;

endmodule

// File: tb/tb_enemy_group.sv
// Directed bench for enemy_group: a movement/health vector table plus
// hand-written draw, pause, abort and screen-bound sequences.
module tb_enemy_group;

  localparam logic [2:0] D_NONE = 3'b000, D_UP = 3'b010, D_DN = 3'b011,
                         D_LT = 3'b100, D_RT = 3'b101;

  typedef struct {
    logic [8:0] linkX;
    logic [7:0] linkY;
    logic [3:0] coll;
    logic [3:0] hitV;
    int         chk;
    logic [8:0] expX;
    logic [7:0] expY;
    logic [2:0] expDir;
    logic [3:0] expAlive;
    logic       expAllDead;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  vec_t vecs [11];

  enemy_group_if #(.NUM_ENEMIES(4)) bus ();

  enemy_group #(.NUM_ENEMIES(4), .MAX_HEALTH(3), .RAND_MOVE(0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] posX(input int e);
    return 9'(bus.enemy_x_pos >> (9 * e));
  endfunction
  function automatic logic [7:0] posY(input int e);
    return 8'(bus.enemy_y_pos >> (8 * e));
  endfunction
  function automatic logic [2:0] dirOf(input int e);
    return 3'(bus.enemy_direction >> (3 * e));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("%s x%0d", tag, e), 32'(posX(e)), 32 + 48 * e);
      check($sformatf("%s y%0d", tag, e), 32'(posY(e)), 96);
      check($sformatf("%s dir%0d", tag, e), 32'(dirOf(e)), 32'(D_DN));
    end
    check({tag, " alive"}, 32'(bus.enemy_alive), 32'hF);
    check({tag, " all_dead"}, 32'(bus.all_dead), 0);
    check({tag, " sprite_addr"}, 32'(bus.sprite_addr), 0);
    check({tag, " x_draw"}, 32'(bus.enemy_x_draw), 0);
    check({tag, " y_draw"}, 32'(bus.enemy_y_draw), 0);
    check({tag, " VGA_write"}, 32'(bus.VGA_write), 0);
    check({tag, " draw_done"}, 32'(bus.draw_done), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.link_x_pos = v.linkX;
    bus.link_y_pos = v.linkY;
    bus.gen_move   = 1'b1;
    @(negedge clock);
    bus.gen_move     = 1'b0;
    bus.move_enemies = 1'b1;
    bus.collision    = v.coll;
    bus.hit          = v.hitV;
    @(negedge clock);
    bus.move_enemies = 1'b0;
    bus.collision    = 4'b0;
    bus.hit          = 4'b0;
  endtask

  task automatic moveOnly();
    bus.move_enemies = 1'b1;
    @(negedge clock);
    bus.move_enemies = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    check($sformatf("vec%0d x", n), 32'(posX(v.chk)), 32'(v.expX));
    check($sformatf("vec%0d y", n), 32'(posY(v.chk)), 32'(v.expY));
    check($sformatf("vec%0d dir", n), 32'(dirOf(v.chk)), 32'(v.expDir));
    check($sformatf("vec%0d alive", n), 32'(bus.enemy_alive), 32'(v.expAlive));
    check($sformatf("vec%0d all_dead", n), 32'(bus.all_dead), 32'(v.expAllDead));
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic runDraw(input logic [5:0] col, input int nAlive, input int slotX[4],
                         input logic [5:0] base, input int pauseAt,
                         output int writes, output int dones, output int badPix,
                         output int pauseWrites);
    int         k, e;
    logic [9:0] prevAddr, expAddr;
    logic [5:0] colExp;
    bit         paused, finished;
    writes = 0; dones = 0; badPix = 0; pauseWrites = 0;
    paused = 0; finished = 0; prevAddr = '0;
    bus.colour       = col;
    bus.draw_enemies = 1'b1;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clock);
      if (bus.VGA_write) begin
        e = writes / 256;
        k = writes % 256;
        colExp  = base + 6'(k % 16);
        expAddr = {4'(k / 16), colExp};
        if (e >= nAlive || bus.enemy_x_draw !== 9'(slotX[e] + k % 16) ||
            bus.enemy_y_draw !== 8'(96 + k / 16) || prevAddr !== expAddr)
          badPix++;
        writes++;
      end
      if (bus.draw_done) begin
        dones++;
        finished = 1;
        bus.draw_enemies = 1'b0;
      end
      prevAddr = bus.sprite_addr;
      if (!paused && pauseAt > 0 && writes == pauseAt) begin
        paused = 1;
        bus.draw_enemies = 1'b0;
        repeat (6) begin
          @(negedge clock);
          if (bus.VGA_write) pauseWrites++;
          if (bus.draw_done) dones++;
          prevAddr = bus.sprite_addr;
        end
        bus.draw_enemies = 1'b1;
      end
    end
    bus.draw_enemies = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (bus.draw_done) dones++;
      if (bus.VGA_write) writes++;
    end
  endtask

  initial begin
    int   writes, dones, badPix, pauseWrites, earlyDone, lateEvents;
    bit   reached;
    vec_t v;

    vecs[0]  = '{9'd32,  8'd50,  4'b0000, 4'b0000, 0, 9'd32,  8'd95, D_UP,   4'b1111, 1'b0};
    vecs[1]  = '{9'd50,  8'd95,  4'b0010, 4'b0000, 1, 9'd80,  8'd95, D_LT,   4'b1111, 1'b0};
    vecs[2]  = '{9'd50,  8'd95,  4'b0000, 4'b0100, 2, 9'd126, 8'd95, D_LT,   4'b1111, 1'b0};
    vecs[3]  = '{9'd50,  8'd95,  4'b0100, 4'b0100, 2, 9'd126, 8'd95, D_LT,   4'b1111, 1'b0};
    vecs[4]  = '{9'd50,  8'd95,  4'b0100, 4'b0100, 2, 9'd126, 8'd95, D_LT,   4'b1011, 1'b0};
    vecs[5]  = '{9'd50,  8'd95,  4'b0000, 4'b0100, 2, 9'd126, 8'd95, D_LT,   4'b1011, 1'b0};
    vecs[6]  = '{9'd171, 8'd95,  4'b0000, 4'b0000, 3, 9'd171, 8'd95, D_NONE, 4'b1011, 1'b0};
    vecs[7]  = '{9'd171, 8'd200, 4'b0000, 4'b0000, 0, 9'd38,  8'd96, D_DN,   4'b1011, 1'b0};
    vecs[8]  = '{9'd171, 8'd200, 4'b1011, 4'b1011, 0, 9'd38,  8'd96, D_DN,   4'b1011, 1'b0};
    vecs[9]  = '{9'd171, 8'd200, 4'b1011, 4'b1011, 1, 9'd77,  8'd96, D_DN,   4'b1011, 1'b0};
    vecs[10] = '{9'd171, 8'd200, 4'b1011, 4'b1011, 3, 9'd171, 8'd96, D_DN,   4'b0000, 1'b1};

    bus.init = 1'b0; bus.gen_move = 1'b0; bus.move_enemies = 1'b0; bus.draw_enemies = 1'b0;
    bus.link_x_pos = 9'd0; bus.link_y_pos = 8'd0; bus.collision = 4'b0; bus.hit = 4'b0;
    bus.colour = 6'h01;
    repeat (3) @(negedge clock);
    checkResetState("reset");
    reset = 1'b0;
    @(negedge clock);

    for (int n = 0; n < 11; n++) begin
      applyStimulus(vecs[n]);
      checkOutput(vecs[n], n);
    end

    // Nobody alive: draw_done two cycles after draw_enemies rises.
    bus.draw_enemies = 1'b1;
    @(negedge clock);
    check("empty done c1", 32'(bus.draw_done), 0);
    @(negedge clock);
    check("empty done c2", 32'(bus.draw_done), 1);
    bus.draw_enemies = 1'b0;
    @(negedge clock);
    check("empty done c3", 32'(bus.draw_done), 0);

    bus.init = 1'b1;
    @(negedge clock);
    bus.init = 1'b0;
    checkResetState("init");

    // Face everyone UP, kill enemy2 without moving, then draw with a pause.
    v = '{9'd32, 8'd50, 4'b1111, 4'b0100, 0, 9'd0, 8'd0, 3'd0, 4'd0, 1'b0};
    repeat (3) applyStimulus(v);
    check("seqA alive", 32'(bus.enemy_alive), 32'hB);
    runDraw(6'h01, 3, '{32, 80, 176, 0}, 6'd32, 300, writes, dones, badPix, pauseWrites);
    check("seqA writes", writes, 768);
    check("seqA dones", dones, 1);
    check("seqA bad pixels", badPix, 0);
    check("seqA pause writes", pauseWrites, 0);

    doReset();
    runDraw(6'h3F, 4, '{32, 80, 128, 176}, 6'd0, 0, writes, dones, badPix, pauseWrites);
    check("transparent writes", writes, 0);
    check("transparent dones", dones, 1);

    // Abort during pixel 100 of enemy1.
    doReset();
    bus.colour = 6'h01;
    bus.draw_enemies = 1'b1;
    writes = 0; earlyDone = 0; reached = 0;
    for (int cyc = 0; cyc < 2000 && !reached; cyc++) begin
      @(negedge clock);
      if (bus.VGA_write) writes++;
      if (bus.draw_done) earlyDone++;
      if (writes == 357) reached = 1;
    end
    check("abort reached", 32'(reached), 1);
    check("abort early done", earlyDone, 0);
    reset = 1'b1;
    bus.draw_enemies = 1'b0;
    @(negedge clock);
    checkResetState("abort");
    reset = 1'b0;
    lateEvents = 0;
    repeat (300) begin
      @(negedge clock);
      if (bus.draw_done || bus.VGA_write) lateEvents++;
    end
    check("abort late events", lateEvents, 0);

    // Screen bounds in all four directions.
    doReset();
    v = '{9'd0, 8'd96, 4'b0000, 4'b0000, 0, 9'd0, 8'd0, 3'd0, 4'd0, 1'b0};
    repeat (32) applyStimulus(v);
    repeat (3) moveOnly();
    check("left clamp x0", 32'(posX(0)), 0);
    check("left clamp dir0", 32'(dirOf(0)), 32'(D_LT));
    check("left free x1", 32'(posX(1)), 45);
    v.linkX = 9'd511;
    repeat (200) applyStimulus(v);
    check("right clamp x3", 32'(posX(3)), 304);
    check("right clamp dir3", 32'(dirOf(3)), 32'(D_RT));
    check("right free x0", 32'(posX(0)), 200);
    v.linkX = 9'd0; v.linkY = 8'd255;
    repeat (140) applyStimulus(v);
    check("down clamp y0", 32'(posY(0)), 224);
    v.linkY = 8'd0;
    repeat (224) applyStimulus(v);
    repeat (3) moveOnly();
    check("up clamp y0", 32'(posY(0)), 0);
    check("up clamp dir0", 32'(dirOf(0)), 32'(D_UP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
